// File: rtl/img_if_pkg.sv
// rtl/img_if_pkg.sv - shared decode constants and types for the image-buffer custom-instruction front end
//
// Purpose : opcode/funct constants of the image custom instructions, STAT word
//           bit positions, the decoded-operation and FSM state enums, and the
//           instruction decode helper.
// Ports   : none (package).
// Options : IMG_IF_RANGE_ERR_EN is consumed by the top, not here.
package img_if_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'h33;
   localparam logic [6:0] F7_IMG     = 7'h06;
   localparam logic [2:0] F3_IM_WR   = 3'b000;
   localparam logic [2:0] F3_IM_RD   = 3'b001;
   localparam logic [2:0] F3_IM_STAT = 3'b010;

   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_RVALID = 2;
   localparam int STAT_ERR    = 3;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_WR   = 2'd1,
      OP_RD   = 2'd2,
      OP_STAT = 2'd3
   } img_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_REQ  = 2'd2,
      ST_RESP = 2'd3
   } img_state_e;

   // Only the opcode, funct3 and funct7 fields take part in decode; every
   // other encoding (including reserved funct3 values) decodes to OP_NONE.
   function automatic img_op_e decode_op(input logic [6:0] opcode,
                                         input logic [2:0] funct3,
                                         input logic [6:0] funct7);
      img_op_e op;
      op = OP_NONE;
      if (opcode == OPC_RTYPE && funct7 == F7_IMG) begin
         case (funct3)
            F3_IM_WR:   op = OP_WR;
            F3_IM_RD:   op = OP_RD;
            F3_IM_STAT: op = OP_STAT;
            default:    op = OP_NONE;
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/img_if_buf.sv
// rtl/img_if_buf.sv - single-port image RAM with synchronous write and registered read
//
// Purpose : DEPTH x DATA_W pixel store. Contents are never reset.
// Ports   : clk   - clock, rising edge
//           we    - write strobe (writes wdata at addr)
//           re    - read strobe (loads rdata from addr)
//           addr  - linear pixel address, shared by read and write
//           wdata - pixel to write
//           rdata - registered read data, valid the cycle after re
module img_if_buf #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              addr_ok;

   // Addresses beyond the array never touch it; reads there return zero.
   assign addr_ok = (32'(addr) < 32'(DEPTH));
   assign idx     = addr[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (we && addr_ok) begin
         mem[idx] <= wdata;
      end
      if (re) begin
         rdata <= addr_ok ? mem[idx] : '0;
      end
   end

endmodule

// File: rtl/rv32i_rtype_layer_img_if.sv
// rtl/rv32i_rtype_layer_img_if.sv - RV32I R-type (funct7=0x06) image buffer instruction front end
//
// Purpose : Accepts IM_WR / IM_RD / IM_STAT custom instructions, owns an
//           IMG_H x IMG_W pixel buffer and returns results through a
//           register-file write port. One instruction outstanding at a time.
// Ports   : clk, rst (synchronous, active-low)
//           instr_valid/instr_ready - instruction handshake
//           instr, rs1_val ({row,col}), rs2_val (write data), rd_addr
//           rd_we/rd_waddr/rd_wdata - one-cycle writeback
//           accel_busy, accel_done, accel_C_valid - accelerator status
// Options : define IMG_IF_RANGE_ERR_EN to add a sticky out-of-range error
//           flag reported in STAT bit 3 (reads 0 otherwise).
module rv32i_rtype_layer_img_if
   import img_if_pkg::*;
#(
   parameter int IMG_H  = 8,
   parameter int IMG_W  = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [4:0]  rd_addr,
   output logic        rd_we,
   output logic [4:0]  rd_waddr,
   output logic [31:0] rd_wdata,
   output logic        accel_busy,
   output logic        accel_done,
   output logic        accel_C_valid
);

   localparam int DEPTH = IMG_H * IMG_W;

   img_state_e        state_q, state_d;
   img_op_e           op_dec, op_q;
   logic              accept;
   logic [15:0]       in_row, in_col;
   logic              in_range;
   logic [ADDR_W-1:0] in_addr;

   logic [ADDR_W-1:0] addr_q;
   logic              range_ok_q;
   logic [DATA_W-1:0] wdata_q;
   logic [4:0]        rd_waddr_q;
   logic [31:0]       stat_q;
   logic [31:0]       stat_word;
   logic              done_s, rvalid_s, err_s;

   logic              seq_we_q, cpu_rd_req_q;
   logic              buf_we, buf_re;
   logic [DATA_W-1:0] buf_rdata;

   logic              unused_bits;

   assign op_dec   = decode_op(instr[6:0], instr[14:12], instr[31:25]);
   assign accept   = instr_valid && instr_ready;
   assign in_row   = rs1_val[31:16];
   assign in_col   = rs1_val[15:0];
   assign in_range = (in_row < 16'(IMG_H)) && (in_col < 16'(IMG_W));
   assign in_addr  = ADDR_W'(32'(in_row) * 32'(IMG_W) + 32'(in_col));

   // Register-index and rs2 fields are not part of the decode.
   assign unused_bits = ^{instr[24:15], instr[11:7], rs2_val};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            // Non-matching words are consumed here and leave no trace.
            if (accept) begin
               case (op_dec)
                  OP_WR:           state_d = ST_WR;
                  OP_RD, OP_STAT:  state_d = ST_REQ;
                  default:         state_d = ST_IDLE;
               endcase
            end
         end
         ST_WR:   state_d = ST_IDLE;
         ST_REQ:  state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      instr_ready   = 1'b0;
      seq_we_q      = 1'b0;
      cpu_rd_req_q  = 1'b0;
      rd_we         = 1'b0;
      accel_C_valid = 1'b0;
      accel_done    = 1'b0;
      accel_busy    = 1'b0;
      case (state_q)
         ST_IDLE: instr_ready  = 1'b1;
         ST_WR:   seq_we_q     = 1'b1;
         ST_REQ:  cpu_rd_req_q = 1'b1;
         ST_RESP: rd_we        = 1'b1;
         default: instr_ready  = 1'b0;
      endcase
      accel_C_valid = rd_we && (op_q == OP_RD);
      // A status read is not an accelerator operation, so it never pulses done.
      accel_done    = seq_we_q || accel_C_valid;
      accel_busy    = !instr_ready;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q       <= OP_NONE;
         addr_q     <= '0;
         range_ok_q <= 1'b0;
         wdata_q    <= '0;
         rd_waddr_q <= '0;
         stat_q     <= '0;
         done_s     <= 1'b0;
         rvalid_s   <= 1'b0;
      end else begin
         if (accept && op_dec != OP_NONE) begin
            op_q       <= op_dec;
            addr_q     <= in_addr;
            range_ok_q <= in_range;
            wdata_q    <= rs2_val[DATA_W-1:0];
            if (op_dec != OP_WR) begin
               rd_waddr_q <= rd_addr;
            end
         end
         if (cpu_rd_req_q && op_q == OP_STAT) begin
            stat_q <= stat_word;
         end
         if (accel_done) begin
            done_s <= 1'b1;
         end
         if (accel_C_valid) begin
            rvalid_s <= 1'b1;
         end
      end
   end

`ifdef IMG_IF_RANGE_ERR_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_s <= 1'b0;
      end else if (accept && (op_dec == OP_WR || op_dec == OP_RD) && !in_range) begin
         err_s <= 1'b1;
      end
   end
`else
   assign err_s = 1'b0;
`endif

   always_comb begin
      stat_word              = '0;
      // Only one instruction is ever outstanding, so while a STAT samples
      // the flags no other operation can be in flight.
      stat_word[STAT_BUSY]   = 1'b0;
      stat_word[STAT_DONE]   = done_s;
      stat_word[STAT_RVALID] = rvalid_s;
      stat_word[STAT_ERR]    = err_s;
   end

   // Read data leaves the RAM register directly, so the pixel and rd_we
   // appear in the same cycle without an extra output flop.
   always_comb begin
      rd_wdata = '0;
      if (rd_we) begin
         if (op_q == OP_RD) begin
            rd_wdata = range_ok_q ? 32'(buf_rdata) : 32'h0;
         end else begin
            rd_wdata = stat_q;
         end
      end
   end

   assign rd_waddr = rd_waddr_q;

   // ------------------------------------------------------------- buffer
   assign buf_we = seq_we_q && range_ok_q;
   assign buf_re = cpu_rd_req_q && (op_q == OP_RD) && range_ok_q;

   img_if_buf #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .re    (buf_re),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (buf_rdata)
   );

endmodule

// File: tb/tb_rv32i_rtype_layer_img_if.sv
// tb/tb_rv32i_rtype_layer_img_if.sv - randomized self-checking bench for rv32i_rtype_layer_img_if
module tb_rv32i_rtype_layer_img_if;

   localparam int K_DROP = 0;
   localparam int K_WR   = 1;
   localparam int K_RD   = 2;
   localparam int K_STAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic        accel_busy;
   logic        accel_done;
   logic        accel_C_valid;

   int tests    = 0;
   int fails    = 0;
   int busy_bad = 0;

   // Reference model: pixel array plus sticky flags.
   logic [31:0] model_mem [64];
   bit          m_done, m_rvalid, m_err;

   logic [31:0] pt_rs1  [4] = '{32'h0000_0000, 32'h0000_0001, 32'h0002_0003, 32'h0007_0007};
   logic [31:0] pt_data [4] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

   always #5 clk = ~clk;

   rv32i_rtype_layer_img_if dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .rs1_val       (rs1_val),
      .rs2_val       (rs2_val),
      .rd_addr       (rd_addr),
      .rd_we         (rd_we),
      .rd_waddr      (rd_waddr),
      .rd_wdata      (rd_wdata),
      .accel_busy    (accel_busy),
      .accel_done    (accel_done),
      .accel_C_valid (accel_C_valid)
   );

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
      logic [31:0] w;
      w = $urandom;
      w[31:25] = f7;
      w[14:12] = f3;
      w[6:0]   = op;
      return w;
   endfunction

   // Expected handshake signature per instruction class, taken from the
   // timing rules: {rd_we count, rd_we cycle, done count, done cycle,
   // C_valid count, first ready cycle}, cycles counted after acceptance.
   function automatic logic [23:0] exp_sig(input int kind);
      case (kind)
         K_WR:    return {4'd0, 4'd0, 4'd1, 4'd1, 4'd0, 4'd2};
         K_RD:    return {4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd3};
         K_STAT:  return {4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd3};
         default: return {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
      endcase
   endfunction

   task automatic model_step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                             output int kind, output logic [31:0] exp);
      int row, col;
      bit inr, err_bit;
      row  = int'(a[31:16]);
      col  = int'(a[15:0]);
      inr  = (row < 8) && (col < 8);
      kind = K_DROP;
      exp  = 32'h0;
      if (ins[6:0] == 7'h33 && ins[31:25] == 7'h06) begin
         case (ins[14:12])
            3'b000:  kind = K_WR;
            3'b001:  kind = K_RD;
            3'b010:  kind = K_STAT;
            default: kind = K_DROP;
         endcase
      end
`ifdef IMG_IF_RANGE_ERR_EN
      err_bit = m_err;
`else
      err_bit = 1'b0;
`endif
      case (kind)
         K_WR: begin
            if (inr) model_mem[row*8+col] = b;
            else m_err = 1'b1;
            m_done = 1'b1;
         end
         K_RD: begin
            exp = inr ? model_mem[row*8+col] : 32'h0;
            if (!inr) m_err = 1'b1;
            m_done   = 1'b1;
            m_rvalid = 1'b1;
         end
         K_STAT: exp = {28'h0, err_bit, m_rvalid, m_done, 1'b0};
         default: exp = 32'h0;
      endcase
   endtask

   task automatic do_instr(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, output logic [23:0] sig,
                           output logic [31:0] wd, output logic [4:0] wa);
      int we_cnt, we_cyc, dn_cnt, dn_cyc, cv_cnt, rdy_cyc, guard;
      we_cnt = 0; we_cyc = 0; dn_cnt = 0; dn_cyc = 0; cv_cnt = 0; rdy_cyc = 0;
      wd = 32'h0;
      wa = 5'h0;
      @(negedge clk);
      guard = 0;
      while (!instr_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      tests++;
      if (!instr_ready) begin
         fails++;
         $display("FAIL issue_wait: instr_ready=%0b after %0d cycles, required 1", instr_ready, guard);
      end
      instr_valid = 1'b1;
      instr       = ins;
      rs1_val     = a;
      rs2_val     = b;
      rd_addr     = rd;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin
            @(posedge clk);
            #1;
         end
         if (rd_we) begin
            we_cnt++;
            if (we_cyc == 0) begin
               we_cyc = k;
               wd = rd_wdata;
               wa = rd_waddr;
            end
         end
         if (accel_done) begin
            dn_cnt++;
            if (dn_cyc == 0) dn_cyc = k;
         end
         if (accel_C_valid) cv_cnt++;
         if (instr_ready && rdy_cyc == 0) rdy_cyc = k;
         if (accel_busy !== !instr_ready) busy_bad++;
      end
      sig = {4'(we_cnt), 4'(we_cyc), 4'(dn_cnt), 4'(dn_cyc), 4'(cv_cnt), 4'(rdy_cyc)};
   endtask

   task automatic test_reset();
      instr_valid = 1'b0;
      instr = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0; rd_addr = 5'h0;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      m_done = 1'b0; m_rvalid = 1'b0; m_err = 1'b0;
      @(negedge clk);
      tests++;
      if ({instr_ready, rd_we, accel_busy, accel_done, accel_C_valid} !== 5'b10000) begin
         fails++;
         $display("FAIL reset_ctrl: {ready,we,busy,done,cvalid}=%b required 10000",
                  {instr_ready, rd_we, accel_busy, accel_done, accel_C_valid});
      end
      tests++;
      if (rd_wdata !== 32'h0 || rd_waddr !== 5'h0) begin
         fails++;
         $display("FAIL reset_wb: rd_wdata=%h rd_waddr=%0d required 0/0", rd_wdata, rd_waddr);
      end
   endtask

   task automatic test_stat_after_reset();
      logic [23:0] sig; logic [31:0] wd, exp; logic [4:0] wa; int kind; logic [31:0] ins;
      ins = mk(7'h06, 3'b010, 7'h33);
      model_step(ins, 32'h0, 32'h0, kind, exp);
      do_instr(ins, 32'h0, 32'h0, 5'd3, sig, wd, wa);
      tests++;
      if (sig !== exp_sig(kind)) begin
         fails++; $display("FAIL stat0_timing: sig=%h required %h", sig, exp_sig(kind));
      end
      tests++;
      if (wd !== 32'h0 || wa !== 5'd3) begin
         fails++; $display("FAIL stat0_data: rd_wdata=%h rd_waddr=%0d required 00000000/3", wd, wa);
      end
   endtask

   task automatic test_writes();
      logic [23:0] sig; logic [31:0] wd, exp; logic [4:0] wa; int kind; logic [31:0] ins;
      for (int i = 0; i < 4; i++) begin
         ins = mk(7'h06, 3'b000, 7'h33);
         model_step(ins, pt_rs1[i], pt_data[i], kind, exp);
         do_instr(ins, pt_rs1[i], pt_data[i], 5'd1, sig, wd, wa);
         tests++;
         if (sig !== exp_sig(K_WR)) begin
            fails++; $display("FAIL wr_timing[%0d]: sig=%h required %h", i, sig, exp_sig(K_WR));
         end
      end
   endtask

   task automatic test_readback();
      logic [23:0] sig; logic [31:0] wd, exp; logic [4:0] wa; int kind; logic [31:0] ins;
      for (int i = 0; i < 4; i++) begin
         ins = mk(7'h06, 3'b001, 7'h33);
         model_step(ins, pt_rs1[i], 32'h0, kind, exp);
         do_instr(ins, pt_rs1[i], $urandom, 5'd7, sig, wd, wa);
         tests++;
         if (sig !== exp_sig(K_RD)) begin
            fails++; $display("FAIL rd_timing[%0d]: sig=%h required %h", i, sig, exp_sig(K_RD));
         end
         tests++;
         if (wd !== pt_data[i] || wa !== 5'd7) begin
            fails++; $display("FAIL rd_data[%0d]: rd_wdata=%h rd_waddr=%0d required %h/7", i, wd, wa, pt_data[i]);
         end
      end
   endtask

   task automatic test_status();
      logic [23:0] sig; logic [31:0] wd, exp; logic [4:0] wa; int kind; logic [31:0] ins;
      ins = mk(7'h06, 3'b010, 7'h33);
      model_step(ins, 32'h0, 32'h0, kind, exp);
      do_instr(ins, 32'h0, 32'h0, 5'd3, sig, wd, wa);
      tests++;
      if (sig !== exp_sig(K_STAT)) begin
         fails++; $display("FAIL stat_timing: sig=%h required %h", sig, exp_sig(K_STAT));
      end
      tests++;
      if (wd !== 32'h0000_0006 || wa !== 5'd3) begin
         fails++; $display("FAIL stat_data: rd_wdata=%h rd_waddr=%0d required 00000006/3", wd, wa);
      end
   endtask

   task automatic test_out_of_range();
      logic [23:0] sig; logic [31:0] wd, exp, stat_exp; logic [4:0] wa; int kind; logic [31:0] ins;
      ins = mk(7'h06, 3'b000, 7'h33);
      model_step(ins, 32'h0008_0000, 32'h1234_5678, kind, exp);
      do_instr(ins, 32'h0008_0000, 32'h1234_5678, 5'd2, sig, wd, wa);
      tests++;
      if (sig !== exp_sig(K_WR)) begin
         fails++; $display("FAIL oor_wr_timing: sig=%h required %h", sig, exp_sig(K_WR));
      end
      ins = mk(7'h06, 3'b001, 7'h33);
      model_step(ins, 32'h0008_0000, 32'h0, kind, exp);
      do_instr(ins, 32'h0008_0000, 32'h0, 5'd4, sig, wd, wa);
      tests++;
      if (sig !== exp_sig(K_RD) || wd !== 32'h0) begin
         fails++; $display("FAIL oor_rd: sig=%h rd_wdata=%h required %h/00000000", sig, wd, exp_sig(K_RD));
      end
      ins = mk(7'h06, 3'b001, 7'h33);
      model_step(ins, 32'h0000_0000, 32'h0, kind, exp);
      do_instr(ins, 32'h0000_0000, 32'h0, 5'd5, sig, wd, wa);
      tests++;
      if (wd !== 32'h3F80_0000) begin
         fails++; $display("FAIL oor_keep00: rd_wdata=%h required 3f800000", wd);
      end
`ifdef IMG_IF_RANGE_ERR_EN
      stat_exp = 32'h0000_000E;
`else
      stat_exp = 32'h0000_0006;
`endif
      ins = mk(7'h06, 3'b010, 7'h33);
      model_step(ins, 32'h0, 32'h0, kind, exp);
      do_instr(ins, 32'h0, 32'h0, 5'd3, sig, wd, wa);
      tests++;
      if (wd !== stat_exp) begin
         fails++; $display("FAIL oor_stat: rd_wdata=%h required %h", wd, stat_exp);
      end
   endtask

   task automatic test_nonmatch();
      logic [23:0] sig; logic [31:0] wd, exp; logic [4:0] wa; int kind;
      logic [31:0] junk [3];
      logic [31:0] ins;
      junk[0] = mk(7'h00, 3'b000, 7'h33);
      junk[1] = mk(7'h06, 3'b111, 7'h33);
      junk[2] = mk(7'h06, 3'b001, 7'h13);
      for (int i = 0; i < 3; i++) begin
         model_step(junk[i], 32'h0, 32'hDEAD_BEEF, kind, exp);
         do_instr(junk[i], 32'h0, 32'hDEAD_BEEF, 5'd6, sig, wd, wa);
         tests++;
         if (sig !== exp_sig(K_DROP)) begin
            fails++; $display("FAIL drop_timing[%0d]: sig=%h required %h", i, sig, exp_sig(K_DROP));
         end
      end
      ins = mk(7'h06, 3'b010, 7'h33);
      model_step(ins, 32'h0, 32'h0, kind, exp);
      do_instr(ins, 32'h0, 32'h0, 5'd3, sig, wd, wa);
      tests++;
      if (wd !== exp) begin
         fails++; $display("FAIL drop_stat: rd_wdata=%h required %h", wd, exp);
      end
      ins = mk(7'h06, 3'b001, 7'h33);
      model_step(ins, 32'h0, 32'h0, kind, exp);
      do_instr(ins, 32'h0, 32'h0, 5'd8, sig, wd, wa);
      tests++;
      if (wd !== exp) begin
         fails++; $display("FAIL drop_pixel: rd_wdata=%h required %h", wd, exp);
      end
   endtask

   task automatic test_reset_abort();
      int we_seen;
      logic [23:0] sig; logic [31:0] wd, exp; logic [4:0] wa; int kind; logic [31:0] ins;
      we_seen = 0;
      @(negedge clk);
      instr_valid = 1'b1;
      instr   = mk(7'h06, 3'b001, 7'h33);
      rs1_val = 32'h0;
      rd_addr = 5'd9;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (rd_we) we_seen++;
         if (k == 1) rst = 1'b1;
      end
      m_done = 1'b0; m_rvalid = 1'b0; m_err = 1'b0;
      tests++;
      if (we_seen != 0 || instr_ready !== 1'b1) begin
         fails++; $display("FAIL abort: rd_we pulses=%0d ready=%0b required 0/1", we_seen, instr_ready);
      end
      ins = mk(7'h06, 3'b010, 7'h33);
      model_step(ins, 32'h0, 32'h0, kind, exp);
      do_instr(ins, 32'h0, 32'h0, 5'd3, sig, wd, wa);
      tests++;
      if (wd !== exp) begin
         fails++; $display("FAIL abort_stat: rd_wdata=%h required %h", wd, exp);
      end
   endtask

   task automatic test_random();
      logic [23:0] sig; logic [31:0] wd, exp, ins, a, b; logic [4:0] wa, rd; int kind, sel;
      int bad_sig, bad_data;
      bad_sig = 0; bad_data = 0; busy_bad = 0;
      for (int p = 0; p < 64; p++) begin
         ins = mk(7'h06, 3'b000, 7'h33);
         a = {16'(p / 8), 16'(p % 8)};
         b = $urandom;
         model_step(ins, a, b, kind, exp);
         do_instr(ins, a, b, 5'($urandom), sig, wd, wa);
         if (sig !== exp_sig(kind)) bad_sig++;
      end
      for (int i = 0; i < 80; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: ins = mk(7'h06, 3'b000, 7'h33);
            3, 4, 5: ins = mk(7'h06, 3'b001, 7'h33);
            6, 7:    ins = mk(7'h06, 3'b010, 7'h33);
            8:       ins = mk(7'($urandom_range(0, 5)), 3'($urandom), 7'h33);
            default: ins = mk(7'h06, 3'($urandom_range(3, 7)), 7'h33);
         endcase
         a  = ($urandom_range(0, 15) == 0) ? $urandom
                                           : {16'($urandom_range(0, 9)), 16'($urandom_range(0, 9))};
         b  = $urandom;
         rd = 5'($urandom);
         model_step(ins, a, b, kind, exp);
         do_instr(ins, a, b, rd, sig, wd, wa);
         tests++;
         if (sig !== exp_sig(kind)) begin
            bad_sig++; fails++;
            $display("FAIL rand_timing[%0d]: kind=%0d sig=%h required %h", i, kind, sig, exp_sig(kind));
         end
         if (kind == K_RD || kind == K_STAT) begin
            tests++;
            if (wd !== exp || wa !== rd) begin
               bad_data++; fails++;
               $display("FAIL rand_data[%0d]: kind=%0d rd_wdata=%h rd_waddr=%0d required %h/%0d",
                        i, kind, wd, wa, exp, rd);
            end
         end
      end
      tests++;
      if (bad_sig != 0) begin
         fails++; $display("FAIL rand_summary: %0d timing deviations, required 0", bad_sig);
      end
      tests++;
      if (busy_bad != 0) begin
         fails++; $display("FAIL busy_vs_ready: %0d cycles with accel_busy==instr_ready, required 0", busy_bad);
      end
   endtask

   initial begin
      test_reset();
      test_stat_after_reset();
      test_writes();
      test_readback();
      test_status();
      test_out_of_range();
      test_nonmatch();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
